image_buffer: RTL and testbench

IMAGE_BUFFER -- requirements
Module: image_buffer

---
 rtl/bnn_pkg.sv | 24 ++
 rtl/image_buffer.sv | 182 ++++++++++++++++++
 tb/tb_image_buffer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the BNN image path: default image geometry and the
// state encoding used by the image buffer controller.
// -----------------------------------------------------------------------------
package bnn_pkg;

  // One bit per pixel; 900 pixels packed MSB-first into 113 bytes.
  localparam int IMG_BIT_SIZE_DEFAULT  = 900;
  localparam int IMG_BYTE_SIZE_DEFAULT = 113;

  // Bytes needed to carry a given number of pixel bits.
  function automatic int bytes_for_bits(input int bits);
    return (bits + 7) / 8;
  endfunction

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_FILLING  = 2'd1,
    S_FULL     = 2'd2,
    S_CLEARING = 2'd3
  } buf_state_e;

endpackage : bnn_pkg

// File: rtl/image_buffer.sv
// -----------------------------------------------------------------------------
// image_buffer
// Collects image bytes arriving from the SPI receive path and presents them
// as one flat bit vector to the BNN. Byte k lands in image_out MSB-first:
// byte k bit 7 is pixel 8k, i.e. image_out[IMG_BIT_SIZE-1-8k]. Pad bits of
// the last byte beyond IMG_BIT_SIZE never reach image_out.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset (priority over clear/wr_en)
//   wr_data[7:0]  incoming image byte
//   wr_en         one-cycle strobe per byte
//   clear         request buffer clear (wins over a same-cycle wr_en)
//   buffer_full   all IMG_BYTE_SIZE bytes held
//   buffer_empty  nothing held and not clearing
//   overflow      sticky: a write was attempted while full
//   byte_count    bytes held, 0..IMG_BYTE_SIZE
//   image_out     assembled image, MSB = first pixel
//   checksum[7:0] XOR of accepted bytes (only with IMAGE_BUFFER_CHECKSUM_EN)
//
// Build option: define IMAGE_BUFFER_CHECKSUM_EN to add the checksum output.
// -----------------------------------------------------------------------------
module image_buffer
  import bnn_pkg::*;
#(
  parameter int IMG_BIT_SIZE  = IMG_BIT_SIZE_DEFAULT,
  parameter int IMG_BYTE_SIZE = IMG_BYTE_SIZE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              wr_data,
  input  logic                    wr_en,
  input  logic                    clear,
  output logic                    buffer_full,
  output logic                    buffer_empty,
  output logic                    overflow,
  output logic [6:0]              byte_count,
  output logic [IMG_BIT_SIZE-1:0] image_out
`ifdef IMAGE_BUFFER_CHECKSUM_EN
  ,
  output logic [7:0]              checksum
`endif
);

  localparam logic [6:0] LAST_IDX = 7'(IMG_BYTE_SIZE - 1);

  buf_state_e state_q, state_d;

  logic [IMG_BYTE_SIZE-1:0][7:0] bytes_q;
  logic [6:0]                    count_q, count_d;
  logic                          overflow_q, overflow_d;
  logic                          wr_accept;
  logic                          wr_reject;
  logic                          unused_pad_bits;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. clear overrides everything and keeps re-entering
  // S_CLEARING while held.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_CLEARING;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (wr_en) begin
            state_d = (IMG_BYTE_SIZE == 1) ? S_FULL : S_FILLING;
          end
        end
        S_FILLING: begin
          if (wr_en && (count_q == LAST_IDX)) begin
            state_d = S_FULL;
          end
        end
        S_FULL:     state_d = S_FULL;
        S_CLEARING: state_d = S_EMPTY;
        default:    state_d = S_EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded only from registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    buffer_full  = (state_q == S_FULL);
    buffer_empty = (state_q == S_EMPTY);
    // A byte is stored only while there is room and no clear is pending;
    // a write is counted as overflow only when full and not being cleared.
    wr_accept    = wr_en && !clear &&
                   ((state_q == S_EMPTY) || (state_q == S_FILLING));
    wr_reject    = wr_en && !clear && (state_q == S_FULL);
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q | wr_reject;
    if (state_q == S_CLEARING) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (wr_accept) begin
      count_d = count_q + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage: the accepted byte is written at the slot indexed by the
  // current count, so byte k is always the k-th byte since the last clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      bytes_q <= '0;
    end else if (state_q == S_CLEARING) begin
      bytes_q <= '0;
    end else if (wr_accept) begin
      bytes_q[count_q] <= wr_data;
    end
  end

  // Static pixel wiring: pixel p is bit (7 - p%8) of byte p/8.
  for (genvar gi = 0; gi < IMG_BIT_SIZE; gi++) begin : g_pix
    assign image_out[IMG_BIT_SIZE-1-gi] = bytes_q[gi/8][7-(gi%8)];
  end

  // Pad bits of the last byte are stored but intentionally never used.
  assign unused_pad_bits = ^bytes_q;

  assign byte_count = count_q;
  assign overflow   = overflow_q;

  // ---------------------------------------------------------------------------
  // Optional running checksum over accepted bytes
  // ---------------------------------------------------------------------------
`ifdef IMAGE_BUFFER_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == S_CLEARING) begin
      checksum_d = '0;
    end else if (wr_accept) begin
      checksum_d = checksum_q ^ wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  // Checksum feature not built: no extra port or state.
`endif

endmodule : image_buffer

// File: tb/tb_image_buffer.sv
// -----------------------------------------------------------------------------
// tb_image_buffer
// Directed stimulus for image_buffer. Each stimulus step pushes the outputs
// expected after the next rising edge into a queue; an independent monitor
// samples on the falling edge and compares against the queue head.
// -----------------------------------------------------------------------------
module tb_image_buffer;

  localparam int NBITS  = 900;
  localparam int NBYTES = 113;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       wr_data;
  logic             wr_en;
  logic             clear;
  logic             buffer_full;
  logic             buffer_empty;
  logic             overflow;
  logic [6:0]       byte_count;
  logic [NBITS-1:0] image_out;
`ifdef IMAGE_BUFFER_CHECKSUM_EN
  logic [7:0]       checksum;
`endif

  image_buffer #(
    .IMG_BIT_SIZE  (NBITS),
    .IMG_BYTE_SIZE (NBYTES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .clear        (clear),
    .buffer_full  (buffer_full),
    .buffer_empty (buffer_empty),
    .overflow     (overflow),
    .byte_count   (byte_count),
    .image_out    (image_out)
`ifdef IMAGE_BUFFER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    int               id;
    logic             full;
    logic             empty;
    logic             ovf;
    logic [6:0]       cnt;
    logic             chk_img;
    logic [NBITS-1:0] img;
    logic             chk_cs;
    logic [7:0]       cs;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   step_n = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed reference images.
  logic [NBITS-1:0] img_zero, img_ones, img_a5, img_a53c, img_123456, img_5a, img_tail;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step %0d %s actual=0x%0h required=0x%0h", id, nm, act, req);
    end
  endtask

  task automatic step(input logic we, input logic [7:0] d, input logic clr, input logic r,
                      input logic e_full, input logic e_empty, input logic e_ovf,
                      input logic [6:0] e_cnt, input logic ci, input logic [NBITS-1:0] e_img,
                      input logic ccs, input logic [7:0] e_cs);
    exp_t e;
    wr_en   = we;
    wr_data = d;
    clear   = clr;
    rst     = r;
    e.cyc = cyc + 1; e.id = step_n;
    e.full = e_full; e.empty = e_empty; e.ovf = e_ovf; e.cnt = e_cnt;
    e.chk_img = ci; e.img = e_img; e.chk_cs = ccs; e.cs = e_cs;
    exp_q.push_back(e);
    step_n++;
    @(posedge clk);
    #1;
    wr_en = 1'b0; wr_data = 8'h00; clear = 1'b0; rst = 1'b0;
  endtask

  // Monitor: compares outputs at the falling edge after each stimulus edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      exp_t s;
      s = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL step %0d sample_missed actual_cycle=%0d required_cycle=%0d", s.id, cyc, s.cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.id, "buffer_full",  32'(buffer_full),  32'(e.full));
      chk(e.id, "buffer_empty", 32'(buffer_empty), 32'(e.empty));
      chk(e.id, "overflow",     32'(overflow),     32'(e.ovf));
      chk(e.id, "byte_count",   32'(byte_count),   32'(e.cnt));
      if (e.chk_img) begin
        checks++;
        if (image_out !== e.img) begin
          errors++;
          $display("FAIL s%0d image act=%h req=%h", e.id, image_out, e.img);
        end
      end
`ifdef IMAGE_BUFFER_CHECKSUM_EN
      if (e.chk_cs) chk(e.id, "checksum", 32'(checksum), 32'(e.cs));
`endif
      $display("txn %0d: cnt=%0d full=%0b empty=%0b ovf=%0b", e.id, byte_count,
               buffer_full, buffer_empty, overflow);
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clear = 1'b0;
    img_zero   = '0;
    img_ones   = '1;
    img_a5     = NBITS'(8'hA5)     << (NBITS - 8);
    img_a53c   = NBITS'(16'hA53C)  << (NBITS - 16);
    img_123456 = NBITS'(24'h123456) << (NBITS - 24);
    img_5a     = NBITS'(8'h5A)     << (NBITS - 8);
    img_tail   = NBITS'(4'hF);   // last byte 0xFF keeps only its upper nibble
    @(posedge clk);
    #1;

    // Reset state
    step(0, 8'h00, 0, 1, 0, 1, 0, 7'd0, 1, img_zero, 1, 8'h00);
    step(0, 8'h00, 0, 1, 0, 1, 0, 7'd0, 1, img_zero, 1, 8'h00);

    // Two bytes, MSB-first placement
    step(1, 8'hA5, 0, 0, 0, 0, 0, 7'd1, 1, img_a5,   1, 8'hA5);
    step(1, 8'h3C, 0, 0, 0, 0, 0, 7'd2, 1, img_a53c, 1, 8'h99);
    step(0, 8'h00, 0, 0, 0, 0, 0, 7'd2, 1, img_a53c, 1, 8'h99);

    // Clear: one clearing cycle, write during it is ignored
    step(0, 8'h00, 1, 0, 0, 0, 0, 7'd2, 1, img_a53c, 1, 8'h99);
    step(1, 8'h77, 0, 0, 0, 1, 0, 7'd0, 1, img_zero, 1, 8'h00);

    // Fill with 0xFF
    for (int i = 1; i <= NBYTES; i++)
      step(1, 8'hFF, 0, 0, (i == NBYTES), 0, 0, 7'(i), (i == NBYTES), img_ones,
           (i == NBYTES), 8'hFF);

    // Overflow: rejected write, sticky flag
    step(1, 8'h00, 0, 0, 1, 0, 1, 7'd113, 1, img_ones, 1, 8'hFF);
    step(0, 8'h00, 0, 0, 1, 0, 1, 7'd113, 1, img_ones, 1, 8'hFF);

    // Clear from full
    step(0, 8'h00, 1, 0, 0, 0, 1, 7'd113, 1, img_ones, 1, 8'hFF);
    step(0, 8'h00, 0, 0, 0, 1, 0, 7'd0,   1, img_zero, 1, 8'h00);

    // Clear and write in the same cycle at count 5
    for (int i = 1; i <= 5; i++)
      step(1, 8'(i), 0, 0, 0, 0, 0, 7'(i), 0, img_zero, 0, 8'h00);
    step(1, 8'hEE, 1, 0, 0, 0, 0, 7'd5, 0, img_zero, 0, 8'h00);
    step(0, 8'h00, 0, 0, 0, 1, 0, 7'd0, 1, img_zero, 1, 8'h00);

    // Clear held for three cycles; empty only after release
    for (int i = 0; i < 3; i++)
      step(0, 8'h00, 1, 0, 0, 0, 0, 7'd0, 1, img_zero, 1, 8'h00);
    step(0, 8'h00, 0, 0, 0, 1, 0, 7'd0, 1, img_zero, 1, 8'h00);

    // Checksum bytes
    step(1, 8'h12, 0, 0, 0, 0, 0, 7'd1, 0, img_zero,   1, 8'h12);
    step(1, 8'h34, 0, 0, 0, 0, 0, 7'd2, 0, img_zero,   1, 8'h26);
    step(1, 8'h56, 0, 0, 0, 0, 0, 7'd3, 1, img_123456, 1, 8'h70);
    step(0, 8'h00, 1, 0, 0, 0, 0, 7'd3, 1, img_123456, 1, 8'h70);
    step(0, 8'h00, 0, 0, 0, 1, 0, 7'd0, 1, img_zero,   1, 8'h00);

    // Reset mid-fill at count 60, with a simultaneous write
    for (int i = 1; i <= 60; i++)
      step(1, 8'(i), 0, 0, 0, 0, 0, 7'(i), 0, img_zero, 0, 8'h00);
    step(1, 8'hCC, 1, 1, 0, 1, 0, 7'd0, 1, img_zero, 1, 8'h00);
    step(1, 8'h5A, 0, 0, 0, 0, 0, 7'd1, 1, img_5a,   1, 8'h5A);

    // Pad bits of the last byte are dropped
    step(0, 8'h00, 1, 0, 0, 0, 0, 7'd1, 1, img_5a,   1, 8'h5A);
    step(0, 8'h00, 0, 0, 0, 1, 0, 7'd0, 1, img_zero, 1, 8'h00);
    for (int i = 1; i < NBYTES; i++)
      step(1, 8'h00, 0, 0, 0, 0, 0, 7'(i), 0, img_zero, 0, 8'h00);
    step(1, 8'hFF, 0, 0, 1, 0, 0, 7'd113, 1, img_tail, 1, 8'hFF);

    // Drain the scoreboard with a bounded wait
    @(negedge clk);
    #1;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_image_buffer
